// File: rtl/intr_ack_seq_if.sv
// intr_ack_seq_if: bus between the CPU core / 8259 side and the interrupt
// acknowledge sequencer. The optional nmi line exists only when
// INTR_ACK_NMI_EN is defined.
interface intr_ack_seq_if;
   logic       intr;            // level request from the PIC int output
   logic       if_flag;         // CPU interrupt-enable flag
   logic       instr_boundary;  // one-cycle pulse between instructions
   logic [7:0] d_in;            // data bus as read by the CPU
   logic       inta_n;          // acknowledge to the PIC, active low
   logic [7:0] vec;             // captured vector
   logic       vec_valid;       // vec holds a fresh vector
   logic       vec_ack;         // core consumed vec
   logic       busy;            // sequencer not idle
`ifdef INTR_ACK_NMI_EN
   logic       nmi;             // non-maskable interrupt, edge triggered

   // Core / PIC side of the link
   modport master (
      output intr, if_flag, instr_boundary, d_in, vec_ack, nmi,
      input  inta_n, vec, vec_valid, busy
   );

   // Sequencer side of the link
   modport slave (
      input  intr, if_flag, instr_boundary, d_in, vec_ack, nmi,
      output inta_n, vec, vec_valid, busy
   );
`else
   // Core / PIC side of the link
   modport master (
      output intr, if_flag, instr_boundary, d_in, vec_ack,
      input  inta_n, vec, vec_valid, busy
   );

   // Sequencer side of the link
   modport slave (
      input  intr, if_flag, instr_boundary, d_in, vec_ack,
      output inta_n, vec, vec_valid, busy
   );
`endif
endinterface

// File: rtl/intr_ack_seq.sv
// intr_ack_seq: CPU-side interrupt acknowledge sequencer placed after an 8259
// PIC. At an instruction boundary with IF set it runs the 8088-style two-pulse
// INTA sequence, captures the vector byte during the second pulse and offers
// it to the core with a valid/ack handshake.
// Optional feature macro: INTR_ACK_NMI_EN adds an edge-triggered nmi input
// that is serviced at an instruction boundary with the fixed vector 8'h02 and
// without any INTA pulses.
module intr_ack_seq #(
   parameter int INTA_LOW_CYC = 2,   // clocks inta_n is low per pulse, 1..15
   parameter int INTA_GAP_CYC = 2    // clocks inta_n is high between pulses, 1..15
) (
   input  logic          clk,
   input  logic          reset,
   intr_ack_seq_if.slave bus
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_ACK1 = 3'd1,
      ST_GAP  = 3'd2,
      ST_ACK2 = 3'd3,
      ST_HOLD = 3'd4
   } state_t;

   // The counter is loaded with N-1 on entry and the phase ends when it reads
   // zero, so each phase lasts exactly N clocks.
   localparam logic [3:0] LOW_LOAD = 4'(INTA_LOW_CYC - 1);
   localparam logic [3:0] GAP_LOAD = 4'(INTA_GAP_CYC - 1);
   localparam logic [7:0] NMI_VEC  = 8'h02;

   // Out-of-range timing parameters would wrap the 4-bit counter; stop elaboration.
   if ((INTA_LOW_CYC < 1) || (INTA_LOW_CYC > 15)) begin : g_bad_low_cyc
      $error("intr_ack_seq: INTA_LOW_CYC must be in 1..15");
   end
   if ((INTA_GAP_CYC < 1) || (INTA_GAP_CYC > 15)) begin : g_bad_gap_cyc
      $error("intr_ack_seq: INTA_GAP_CYC must be in 1..15");
   end

   state_t     state_q;
   logic [3:0] cnt_q;
   logic       inta_n_q;
   logic [7:0] vec_q;
   logic       vec_valid_q;
   logic       busy_q;

   logic       accept_intr;   // maskable request taken this cycle
   logic       accept_nmi;    // pending NMI taken this cycle

   // A maskable request counts only when all three qualifiers coincide; a
   // request without a boundary is not remembered since intr is a level.
   assign accept_intr = bus.intr & bus.if_flag & bus.instr_boundary;

`ifdef INTR_ACK_NMI_EN
   logic nmi_prev_q;
   logic nmi_pend_q;
   logic nmi_rise;

   assign nmi_rise   = bus.nmi & ~nmi_prev_q;
   // NMI ignores if_flag and wins over intr whenever the sequencer is idle.
   assign accept_nmi = bus.instr_boundary & nmi_pend_q & (state_q == ST_IDLE);

   // Edge detector and pending flag; a new edge wins over a same-cycle clear
   // so it is never lost.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         nmi_prev_q <= 1'b0;
         nmi_pend_q <= 1'b0;
      end else begin
         nmi_prev_q <= bus.nmi;
         if (nmi_rise) begin
            nmi_pend_q <= 1'b1;
         end else if (accept_nmi) begin
            nmi_pend_q <= 1'b0;
         end else begin
            nmi_pend_q <= nmi_pend_q;
         end
      end
   end
`else
   assign accept_nmi = 1'b0;
`endif

   // Sequencer FSM: state, phase counter and all registered outputs. Reset is
   // asynchronous so inta_n is released immediately even mid-pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 4'd0;
         inta_n_q    <= 1'b1;
         vec_q       <= 8'h00;
         vec_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (accept_nmi) begin
                  // NMI skips the bus cycles and presents its fixed vector.
                  state_q     <= ST_HOLD;
                  vec_q       <= NMI_VEC;
                  vec_valid_q <= 1'b1;
                  busy_q      <= 1'b1;
               end else if (accept_intr) begin
                  state_q  <= ST_ACK1;
                  cnt_q    <= LOW_LOAD;
                  inta_n_q <= 1'b0;
                  busy_q   <= 1'b1;
               end else begin
                  state_q <= ST_IDLE;
               end
            end

            ST_ACK1: begin
               // First pulse: the PIC freezes its priority resolution.
               if (cnt_q == 4'd0) begin
                  state_q  <= ST_GAP;
                  cnt_q    <= GAP_LOAD;
                  inta_n_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end

            ST_GAP: begin
               if (cnt_q == 4'd0) begin
                  state_q  <= ST_ACK2;
                  cnt_q    <= LOW_LOAD;
                  inta_n_q <= 1'b0;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end

            ST_ACK2: begin
               // Second pulse: the PIC drives the vector; it is captured on
               // the edge closing the last low cycle, whatever the bus holds
               // (a dropped request yields the PIC's spurious vector).
               if (cnt_q == 4'd0) begin
                  state_q     <= ST_HOLD;
                  cnt_q       <= 4'd0;
                  inta_n_q    <= 1'b1;
                  vec_q       <= bus.d_in;
                  vec_valid_q <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end

            ST_HOLD: begin
               // vec stays stable until consumed and is kept afterwards.
               if (bus.vec_ack) begin
                  state_q     <= ST_IDLE;
                  vec_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
               end else begin
                  state_q <= ST_HOLD;
               end
            end

            default: begin
               state_q     <= ST_IDLE;
               cnt_q       <= 4'd0;
               inta_n_q    <= 1'b1;
               vec_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.inta_n    = inta_n_q;
   assign bus.vec       = vec_q;
   assign bus.vec_valid = vec_valid_q;
   assign bus.busy      = busy_q;

endmodule

// File: tb/tb_intr_ack_seq.sv
// tb_intr_ack_seq: two sequencers (L=2/G=2 and L=3/G=1) share one stimulus
// stream; a phase-window model predicts every output each cycle, and directed
// literal checks pin the model at the documented cycle numbers.
module tb_intr_ack_seq;

   localparam int LA = 2, GA = 2;   // instance A timing
   localparam int LB = 3, GB = 1;   // instance B timing
`ifdef INTR_ACK_NMI_EN
   localparam bit NMI_EN = 1'b1;
`else
   localparam bit NMI_EN = 1'b0;
`endif

   logic       clk;
   logic       reset;
   logic       intr, if_flag, instr_boundary, vec_ack, nmi;
   logic [7:0] d_in;

   int n_cmp = 0;
   int n_bad = 0;

   intr_ack_seq_if ifa ();
   intr_ack_seq_if ifb ();

   assign ifa.intr = intr;  assign ifa.if_flag = if_flag;  assign ifa.instr_boundary = instr_boundary;
   assign ifa.d_in = d_in;  assign ifa.vec_ack = vec_ack;
   assign ifb.intr = intr;  assign ifb.if_flag = if_flag;  assign ifb.instr_boundary = instr_boundary;
   assign ifb.d_in = d_in;  assign ifb.vec_ack = vec_ack;
`ifdef INTR_ACK_NMI_EN
   assign ifa.nmi = nmi;
   assign ifb.nmi = nmi;
`endif

   intr_ack_seq #(.INTA_LOW_CYC(LA), .INTA_GAP_CYC(GA)) u_a (.clk(clk), .reset(reset), .bus(ifa));
   intr_ack_seq #(.INTA_LOW_CYC(LB), .INTA_GAP_CYC(GB)) u_b (.clk(clk), .reset(reset), .bus(ifb));

   logic       out_inta  [2];
   logic       out_busy  [2];
   logic       out_valid [2];
   logic [7:0] out_vec   [2];
   assign out_inta[0] = ifa.inta_n;  assign out_inta[1] = ifb.inta_n;
   assign out_busy[0] = ifa.busy;    assign out_busy[1] = ifb.busy;
   assign out_valid[0] = ifa.vec_valid; assign out_valid[1] = ifb.vec_valid;
   assign out_vec[0] = ifa.vec;      assign out_vec[1] = ifb.vec;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- model ----------------
   // m_k counts cycles since the accept edge (1 = first cycle after it);
   // inta_n is low in windows 1..L and L+G+1..2L+G.
   bit         m_act  [2];
   bit         m_hold [2];
   int         m_k    [2];
   logic [7:0] m_vec  [2];
   bit         m_prev [2];
   bit         m_pend [2];

   function automatic int lc(int i); return (i == 0) ? LA : LB; endfunction
   function automatic int gc(int i); return (i == 0) ? GA : GB; endfunction

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            m_act[i] <= 1'b0; m_hold[i] <= 1'b0; m_k[i] <= 0;
            m_vec[i] <= 8'h00; m_prev[i] <= 1'b0; m_pend[i] <= 1'b0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (!m_act[i]) begin
               if (NMI_EN && instr_boundary && m_pend[i]) begin
                  m_act[i] <= 1'b1; m_hold[i] <= 1'b1; m_vec[i] <= 8'h02;
               end else if (intr && if_flag && instr_boundary) begin
                  m_act[i] <= 1'b1; m_k[i] <= 1;
               end
            end else if (!m_hold[i]) begin
               if (m_k[i] == 2 * lc(i) + gc(i)) begin
                  m_hold[i] <= 1'b1; m_vec[i] <= d_in;
               end
               m_k[i] <= m_k[i] + 1;
            end else if (vec_ack) begin
               m_act[i] <= 1'b0; m_hold[i] <= 1'b0;
            end
            m_pend[i] <= NMI_EN && ((m_pend[i] && !(!m_act[i] && instr_boundary))
                                    || (nmi && !m_prev[i]));
            m_prev[i] <= nmi;
         end
      end
   end

   function automatic logic exp_inta(int i);
      return !(m_act[i] && !m_hold[i] &&
               ((m_k[i] <= lc(i)) || (m_k[i] > lc(i) + gc(i))));
   endfunction

   // ---------------- checking ----------------
   task automatic check(string name, logic [7:0] act, logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cmp_model();
      for (int i = 0; i < 2; i++) begin
         check($sformatf("model_inta_n[%0d]", i), {7'd0, out_inta[i]},  {7'd0, exp_inta(i)});
         check($sformatf("model_busy[%0d]", i),   {7'd0, out_busy[i]},  {7'd0, m_act[i]});
         check($sformatf("model_valid[%0d]", i),  {7'd0, out_valid[i]}, {7'd0, m_hold[i]});
         check($sformatf("model_vec[%0d]", i),    out_vec[i],           m_vec[i]);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      cmp_model();
   endtask

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [8:1] pat_a_inta;
      logic [8:1] pat_b_inta;
      pat_a_inta = 8'b1100_1100;   // A: low cycles 1-2 and 5-6
      pat_b_inta = 8'b1000_1000;   // B: low cycles 1-3 and 5-7

      reset = 1'b1; intr = 1'b0; if_flag = 1'b0; instr_boundary = 1'b0;
      vec_ack = 1'b0; nmi = 1'b0; d_in = 8'h00;
      tick();
      check("rst_inta_n", {7'd0, ifa.inta_n}, 8'd1);
      check("rst_vec", ifa.vec, 8'h00);
      check("rst_valid", {7'd0, ifa.vec_valid}, 8'd0);
      check("rst_busy", {7'd0, ifa.busy}, 8'd0);
      reset = 1'b0;
      tick(); tick();

      // Test 1: basic sequence, vector 8'h08 (cycle 0 is this period)
      intr = 1'b1; if_flag = 1'b1; instr_boundary = 1'b1; d_in = 8'h08;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 1) instr_boundary = 1'b0;
         check($sformatf("t1_a_inta_c%0d", k), {7'd0, ifa.inta_n}, {7'd0, pat_a_inta[k]});
         check($sformatf("t1_b_inta_c%0d", k), {7'd0, ifb.inta_n}, {7'd0, pat_b_inta[k]});
         if (k <= 7) check($sformatf("t1_a_busy_c%0d", k), {7'd0, ifa.busy}, 8'd1);
         check($sformatf("t1_a_valid_c%0d", k), {7'd0, ifa.vec_valid}, (k >= 7) ? 8'd1 : 8'd0);
      end
      check("t1_a_vec", ifa.vec, 8'h08);
      check("t1_b_vec", ifb.vec, 8'h08);

      // Test 3: stall in HOLD, new requests ignored
      instr_boundary = 1'b1; d_in = 8'hAA;
      for (int k = 0; k < 10; k++) begin
         tick();
         check("t3_a_valid", {7'd0, ifa.vec_valid}, 8'd1);
         check("t3_a_vec", ifa.vec, 8'h08);
         check("t3_a_inta_n", {7'd0, ifa.inta_n}, 8'd1);
      end
      instr_boundary = 1'b0; vec_ack = 1'b1;
      tick();
      vec_ack = 1'b0;
      check("t3_a_valid_drop", {7'd0, ifa.vec_valid}, 8'd0);
      check("t3_a_busy_drop", {7'd0, ifa.busy}, 8'd0);
      check("t3_a_vec_kept", ifa.vec, 8'h08);

      // Re-accept right away; this doubles as test 4 (intr dropped in GAP)
      instr_boundary = 1'b1; d_in = 8'h0F;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 1) instr_boundary = 1'b0;
         check($sformatf("t4_a_inta_c%0d", k), {7'd0, ifa.inta_n}, {7'd0, pat_a_inta[k]});
         check($sformatf("t4_b_inta_c%0d", k), {7'd0, ifb.inta_n}, {7'd0, pat_b_inta[k]});
         check($sformatf("t4_b_valid_c%0d", k), {7'd0, ifb.vec_valid}, (k >= 8) ? 8'd1 : 8'd0);
         if (k == 4) intr = 1'b0;
      end
      check("t4_b_vec", ifb.vec, 8'h0F);
      check("t4_a_vec", ifa.vec, 8'h0F);
      vec_ack = 1'b1;
      tick();
      vec_ack = 1'b0;

      // Test 5: reset during ACK2 while inta_n is low
      intr = 1'b1; instr_boundary = 1'b1; d_in = 8'h55;
      for (int k = 1; k <= 5; k++) begin
         tick();
         if (k == 1) instr_boundary = 1'b0;
      end
      check("t5_a_inta_pre", {7'd0, ifa.inta_n}, 8'd0);
      check("t5_b_inta_pre", {7'd0, ifb.inta_n}, 8'd0);
      #2 reset = 1'b1;
      #1;
      check("t5_a_inta_async", {7'd0, ifa.inta_n}, 8'd1);
      check("t5_b_inta_async", {7'd0, ifb.inta_n}, 8'd1);
      check("t5_a_vec", ifa.vec, 8'h00);
      check("t5_a_valid", {7'd0, ifa.vec_valid}, 8'd0);
      tick();
      reset = 1'b0; intr = 1'b0;
      for (int k = 0; k < 10; k++) begin
         tick();
         check("t5_b_valid_never", {7'd0, ifb.vec_valid}, 8'd0);
      end

      // Test 2: IF clear masks the request
      intr = 1'b1; if_flag = 1'b0; instr_boundary = 1'b1;
      for (int k = 0; k < 20; k++) begin
         tick();
         check("t2_a_inta_n", {7'd0, ifa.inta_n}, 8'd1);
         check("t2_a_valid", {7'd0, ifa.vec_valid}, 8'd0);
      end
      instr_boundary = 1'b0;
      tick();

`ifdef INTR_ACK_NMI_EN
      // Test 6a: NMI with IF clear, serviced without INTA pulses
      nmi = 1'b1;
      tick();
      instr_boundary = 1'b1;
      tick();
      instr_boundary = 1'b0;
      check("t6_a_valid", {7'd0, ifa.vec_valid}, 8'd1);
      check("t6_a_vec", ifa.vec, 8'h02);
      check("t6_a_inta_n", {7'd0, ifa.inta_n}, 8'd1);
      check("t6_b_vec", ifb.vec, 8'h02);
      vec_ack = 1'b1;
      tick();
      vec_ack = 1'b0; nmi = 1'b0;

      // Test 6b: NMI edge during an INTR sequence waits for the next boundary
      if_flag = 1'b1; instr_boundary = 1'b1; d_in = 8'h21;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (k == 1) instr_boundary = 1'b0;
         if (k == 2) nmi = 1'b1;
      end
      check("t6_a_intr_vec", ifa.vec, 8'h21);
      check("t6_b_intr_vec", ifb.vec, 8'h21);
      vec_ack = 1'b1;
      tick();
      vec_ack = 1'b0; instr_boundary = 1'b1;
      tick();
      instr_boundary = 1'b0;
      check("t6_a_pend_vec", ifa.vec, 8'h02);
      check("t6_a_pend_valid", {7'd0, ifa.vec_valid}, 8'd1);
      check("t6_a_pend_inta_n", {7'd0, ifa.inta_n}, 8'd1);
      vec_ack = 1'b1;
      tick();
      vec_ack = 1'b0;
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
